// File: rtl/sort_pkg.sv
// sort_pkg: shared state encoding and width helpers for the bubble sort engine.
package sort_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  localparam int DEF_N_ELEM = 4;
  localparam int DEF_W = 8;
  function automatic int idx_w(int n);
    return $clog2(n);
  endfunction
  function automatic int scw(int n);
    return $clog2(n * (n - 1) / 2 + 1);
  endfunction
  localparam int DEF_IDX_W = idx_w(DEF_N_ELEM);
  localparam int DEF_PASS_W = idx_w(DEF_N_ELEM);
endpackage

// File: rtl/sort_cmp_swap.sv
// sort_cmp_swap: single compare-swap cell; equal keys never swap, keeping the sort stable.
module sort_cmp_swap #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         desc,
  output logic [W-1:0] lo_out,
  output logic [W-1:0] hi_out,
  output logic         swapped
);
  assign swapped = desc ? (a < b) : (a > b);
  assign lo_out  = swapped ? b : a;
  assign hi_out  = swapped ? a : b;
endmodule

// File: rtl/sort_engine.sv
// sort_engine: bubble sorter, one adjacent compare per clock, with early exit on a swap-free pass.
module sort_engine
  import sort_pkg::*;
#(
  parameter int N_ELEM = 4,
  parameter int W      = 8,
  parameter int SCW    = scw(N_ELEM)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_desc,
  input  logic [N_ELEM*W-1:0] i_in_data,
  output logic [N_ELEM*W-1:0] o_out_data,
  output logic                o_busy,
  output logic                o_done,
  output logic [SCW-1:0]      o_swap_count
);
  localparam int IW = idx_w(N_ELEM);

  state_e         r_state, w_state_nx;
  logic [W-1:0]   r_buf [N_ELEM];
  logic           r_desc, r_swapped;
  logic [IW-1:0]  r_i, r_pass, w_i1;
  logic [SCW-1:0] r_cnt;
  logic [W-1:0]   w_lo, w_hi;
  logic           w_sw, w_last, w_more;

  assign w_i1   = r_i + IW'(1);
  assign w_last = r_i == IW'(N_ELEM - 2);
  // this cycle's compare counts toward the pass that is ending
  assign w_more = (r_swapped | w_sw) && (r_pass < IW'(N_ELEM - 2));

  sort_cmp_swap #(.W(W)) u_cmp (
    .a      (r_buf[r_i]),
    .b      (r_buf[w_i1]),
    .desc   (r_desc),
    .lo_out (w_lo),
    .hi_out (w_hi),
    .swapped(w_sw)
  );

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nx;

  always_comb begin
    w_state_nx = r_state;
    w_state_nx = (r_state == IDLE) ? (i_start ? SCAN : IDLE) :
                 (r_state == SCAN) ? ((w_last && !w_more) ? DONE : SCAN) : IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int k = 0; k < N_ELEM; k++) r_buf[k] <= '0;
      r_desc    <= 1'b0;
      r_swapped <= 1'b0;
      r_i       <= '0;
      r_pass    <= '0;
      r_cnt     <= '0;
    end else if (r_state == IDLE && i_start) begin
      for (int k = 0; k < N_ELEM; k++) r_buf[k] <= i_in_data[(N_ELEM-1-k)*W +: W];
      r_desc    <= i_desc;
      r_swapped <= 1'b0;
      r_i       <= '0;
      r_pass    <= '0;
      r_cnt     <= '0;
    end else if (r_state == SCAN) begin
      r_buf[r_i]  <= w_lo;
      r_buf[w_i1] <= w_hi;
      if (w_sw) r_cnt <= r_cnt + SCW'(1);
      if (!w_last) begin
        r_i       <= w_i1;
        r_swapped <= r_swapped | w_sw;
      end else if (w_more) begin
        r_i       <= '0;
        r_pass    <= r_pass + IW'(1);
        r_swapped <= 1'b0;
      end
    end

  for (genvar g = 0; g < N_ELEM; g++) begin : g_out
    assign o_out_data[(N_ELEM-1-g)*W +: W] = r_buf[g];
  end

  assign o_busy       = r_state == SCAN;
  assign o_done       = r_state == DONE;
  assign o_swap_count = r_cnt;
endmodule

// File: tb/tb_sort_engine.sv
// tb_sort_engine: scoreboard bench for sort_engine across three parameter sets.
module tb_sort_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic s4, d4, b4, dn4;
  logic [31:0] in4, out4;
  logic [2:0] sc4;
  logic s8, d8, b8, dn8;
  logic [55:0] in8, out8;
  logic [4:0] sc8;
  logic s2, d2, b2, dn2;
  logic [15:0] in2, out2;
  logic [0:0] sc2;

  sort_engine #(.N_ELEM(4), .W(8)) u_dut4 (.i_clk(clk), .i_rst_n(rst_n), .i_start(s4), .i_desc(d4),
    .i_in_data(in4), .o_out_data(out4), .o_busy(b4), .o_done(dn4), .o_swap_count(sc4));
  sort_engine #(.N_ELEM(8), .W(7)) u_dut8 (.i_clk(clk), .i_rst_n(rst_n), .i_start(s8), .i_desc(d8),
    .i_in_data(in8), .o_out_data(out8), .o_busy(b8), .o_done(dn8), .o_swap_count(sc8));
  sort_engine #(.N_ELEM(2), .W(8)) u_dut2 (.i_clk(clk), .i_rst_n(rst_n), .i_start(s2), .i_desc(d2),
    .i_in_data(in2), .o_out_data(out2), .o_busy(b2), .o_done(dn2), .o_swap_count(sc2));

  typedef struct {logic [63:0] data; int cnt; int lat;} exp_t;
  exp_t q[$];
  int n_vec = 0, n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int n_of(int sel); return sel == 0 ? 4 : sel == 1 ? 8 : 2; endfunction
  function automatic int w_of(int sel); return sel == 1 ? 7 : 8; endfunction
  function automatic logic [63:0] g_data(int sel);
    return sel == 0 ? 64'(out4) : sel == 1 ? 64'(out8) : 64'(out2);
  endfunction
  function automatic logic [63:0] g_cnt(int sel);
    return sel == 0 ? 64'(sc4) : sel == 1 ? 64'(sc8) : 64'(sc2);
  endfunction
  function automatic logic g_busy(int sel); return sel == 0 ? b4 : sel == 1 ? b8 : b2; endfunction
  function automatic logic g_done(int sel); return sel == 0 ? dn4 : sel == 1 ? dn8 : dn2; endfunction

  task automatic drive(int sel, logic st, logic ds, logic [63:0] v);
    if (sel == 0) begin s4 = st; d4 = ds; in4 = v[31:0]; end
    else if (sel == 1) begin s8 = st; d8 = ds; in8 = v[55:0]; end
    else begin s2 = st; d2 = ds; in2 = v[15:0]; end
  endtask

  // reference: inversion count plus a stable insertion sort
  function automatic exp_t model(logic [63:0] d, int n, int w, logic desc, int lat);
    exp_t r;
    int e[8];
    int v, j;
    for (int k = 0; k < n; k++) e[k] = int'((d >> ((n - 1 - k) * w)) & ((64'd1 << w) - 1));
    r.cnt = 0;
    for (int a = 0; a < n; a++)
      for (int b = a + 1; b < n; b++)
        if (desc ? e[a] < e[b] : e[a] > e[b]) r.cnt++;
    for (int k = 1; k < n; k++) begin
      v = e[k];
      j = k - 1;
      while (j >= 0 && (desc ? e[j] < v : e[j] > v)) begin
        e[j + 1] = e[j];
        j--;
      end
      e[j + 1] = v;
    end
    r.data = '0;
    for (int k = 0; k < n; k++) r.data |= 64'(e[k]) << ((n - 1 - k) * w);
    r.lat = lat;
    return r;
  endfunction

  // called at a negedge; returns at the negedge of the cycle after done
  task automatic run(int sel, logic [63:0] v, logic desc, int lat, bit abuse);
    exp_t e;
    int cyc = 0;
    bit got = 0, busy_ok = 1;
    q.push_back(model(v, n_of(sel), w_of(sel), desc, lat));
    drive(sel, 1'b1, desc, v);
    @(posedge clk);
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (g_done(sel)) got = 1;
      else begin
        if (!g_busy(sel)) busy_ok = 0;
        if (abuse && cyc == 3) drive(sel, 1'b1, ~desc, ~v);
        else drive(sel, 1'b0, abuse ? ~desc : desc, abuse ? ~v : v);
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("busy_while_sorting", 64'(busy_ok), 64'd1);
    if (abuse) drive(sel, 1'b1, ~desc, ~v);
    e = q.pop_front();
    chk("out_data", g_data(sel), e.data);
    chk("swap_count", g_cnt(sel), 64'(e.cnt));
    if (e.lat >= 0) chk("latency", 64'(cyc), 64'(e.lat));
    @(negedge clk);
    drive(sel, 1'b0, desc, v);
    chk("single_done", 64'(g_done(sel)), 64'd0);
    chk("idle_after_done", 64'(g_busy(sel)), 64'd0);
    chk("out_hold", g_data(sel), e.data);
  endtask

  initial begin
    logic [63:0] hg;
    int dn_seen;
    rst_n = 1'b0;
    drive(0, 0, 0, 0); drive(1, 0, 0, 0); drive(2, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(b4), 64'd0);
    chk("rst_done", 64'(dn4), 64'd0);
    chk("rst_out", 64'(out4), 64'd0);
    chk("rst_cnt", 64'(sc4), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 64'h44434241, 1'b0, 10, 0);
    run(0, 64'h41424344, 1'b0, 4, 0);
    run(0, 64'h41424344, 1'b1, 10, 0);
    run(0, 64'h42414241, 1'b0, 10, 0);
    run(0, 64'h44434241, 1'b0, 10, 1);
    run(0, 64'h41424344, 1'b1, 10, 0);
    for (int k = 0; k < 4; k++) run(0, 64'($urandom), 1'($urandom), -1, 0);
    drive(0, 1'b1, 1'b0, 64'h44434241);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'h44434241);
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 64'(b4), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(b4), 64'd0);
    chk("async_rst_out", 64'(out4), 64'd0);
    chk("async_rst_cnt", 64'(sc4), 64'd0);
    dn_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (dn4) dn_seen++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (dn4) dn_seen++;
    end
    chk("no_done_after_rst", 64'(dn_seen), 64'd0);
    run(0, 64'h44434241, 1'b0, 10, 0);
    hg = '0;
    for (int k = 0; k < 8; k++) hg |= (64'h48 - 64'(k)) << ((7 - k) * 7);
    run(1, hg, 1'b0, 50, 0);
    run(1, hg, 1'b1, 8, 0);
    run(2, 64'h7A30, 1'b0, 2, 0);
    run(2, 64'h307A, 1'b0, 2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
